// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: two-flop input synchronizer, start-bit qualification at
// half a bit, mid-bit data sampling, and single-cycle ready / framing-error pulses.
module uart_rx_core #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       data_ready,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      rx_data_q, rx_data_d;
    logic            ready_q, ready_d;
    logic            ferr_q, ferr_d;
    logic            busy_q, busy_d;
    logic [1:0]      sync_q;
    logic            rx_s;

    assign rx_s = sync_q[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= 2'b11;
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            rx_data_q <= '0;
            ready_q   <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], rx};
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            rx_data_q <= rx_data_d;
            ready_q   <= ready_d;
            ferr_q    <= ferr_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (!rx_s) state_d = START;
            START:     if (cnt_q == HALF_M1) state_d = rx_s ? IDLE : DATA;
            DATA:      if (cnt_q == CNT_MAX && idx_q == 3'd7) state_d = STOP;
            STOP:      if (cnt_q == CNT_MAX) state_d = rx_s ? IDLE : WAIT_IDLE;
            // Hold off while the line is stuck low so a break cannot spawn frames.
            WAIT_IDLE: if (rx_s) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        rx_data_d = rx_data_q;
        ready_d   = 1'b0;
        ferr_d    = 1'b0;
        busy_d    = (state_d != IDLE);
        case (state_q)
            IDLE: cnt_d = '0;
            START: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    idx_d = '0;
                end
            end
            DATA: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_MAX) begin
                    shift_d = {rx_s, shift_q[7:1]};
                    cnt_d   = '0;
                    idx_d   = idx_q + 3'd1;
                end
            end
            STOP: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_MAX) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        rx_data_d = shift_q;
                        ready_d   = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            WAIT_IDLE: cnt_d = '0;
            default:   cnt_d = '0;
        endcase
    end

    assign rx_data    = rx_data_q;
    assign data_ready = ready_q;
    assign frame_err  = ferr_q;
    assign rx_busy    = busy_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core at 16 clocks per bit: framing, timing,
// glitch rejection, break handling, reset abort and baud skew.
module tb_uart_rx_core;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] rx_data;
    logic       data_ready;
    logic       frame_err;
    logic       rx_busy;

    int vectors = 0;
    int miscompares = 0;

    int cyc = 0;
    int last_t0 = 0;
    int win_lo = 1000000;
    int win_hi = 0;
    int dr_cnt = 0, fe_cnt = 0, dr_cyc = 0;
    int pulse_err = 0, excl_err = 0, busy_gap = 0;
    logic dr_prev = 1'b0, fe_prev = 1'b0;
    logic [7:0] dr_q[$];

    uart_rx_core #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .rx_data    (rx_data),
        .data_ready (data_ready),
        .frame_err  (frame_err),
        .rx_busy    (rx_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse bookkeeping, sampled half a cycle after each active edge.
    always @(negedge clk) begin
        if (data_ready) begin
            dr_cnt++;
            dr_q.push_back(rx_data);
            dr_cyc = cyc;
            if (dr_prev) pulse_err++;
            if (frame_err) excl_err++;
        end
        if (frame_err) begin
            fe_cnt++;
            if (fe_prev) pulse_err++;
        end
        dr_prev = data_ready;
        fe_prev = frame_err;
        if (cyc >= win_lo && cyc <= win_hi && !rx_busy) busy_gap++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Caller is positioned at a negedge; bit k uses pa (even k) or pb (odd k).
    task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                              input int pa, input int pb, input int stop_len);
        logic [9:0] bits;
        bits    = {stop_bit, d, 1'b0};
        last_t0 = cyc + 1;
        win_lo  = last_t0 + 2;
        win_hi  = last_t0 + 153;
        for (int k = 0; k < 10; k++) begin
            rx = bits[k];
            repeat ((k == 9) ? stop_len : ((k % 2) ? pb : pa)) @(negedge clk);
        end
        rx = 1'b1;
    endtask

    initial begin
        int dr0, fe0, q0;

        repeat (3) @(negedge clk);
        chk("reset_rx_data", rx_data, 8'h00);
        chk("reset_ready", data_ready, 1'b0);
        chk("reset_ferr", frame_err, 1'b0);
        chk("reset_busy", rx_busy, 1'b0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Single frame, nominal rate
        send_frame(8'hA5, 1'b1, CPB, CPB, CPB);
        repeat (10) @(negedge clk);
        chk("single_cnt", dr_cnt, 1);
        chk("single_val", dr_q[0], 8'hA5);
        chk("single_rx_data", rx_data, 8'hA5);
        chk("single_latency", dr_cyc - last_t0, 154);
        chk("single_ferr", fe_cnt, 0);
        chk("single_busy_gap", busy_gap, 0);
        chk("single_busy_end", rx_busy, 1'b0);

        // Back-to-back with shortened stop bits
        dr0 = dr_cnt; q0 = dr_q.size();
        send_frame(8'h00, 1'b1, CPB, CPB, 10);
        send_frame(8'hFF, 1'b1, CPB, CPB, 10);
        send_frame(8'h3C, 1'b1, CPB, CPB, CPB);
        repeat (10) @(negedge clk);
        chk("b2b_cnt", dr_cnt - dr0, 3);
        chk("b2b_val0", dr_q[q0], 8'h00);
        chk("b2b_val1", dr_q[q0+1], 8'hFF);
        chk("b2b_val2", dr_q[q0+2], 8'h3C);
        chk("b2b_ferr", fe_cnt, 0);

        // False start: 4 low cycles, shorter than half a bit
        dr0 = dr_cnt; fe0 = fe_cnt;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        chk("fs_busy_start", rx_busy, 1'b1);
        repeat (20) @(negedge clk);
        chk("fs_busy_idle", rx_busy, 1'b0);
        chk("fs_ready", dr_cnt - dr0, 0);
        chk("fs_ferr", fe_cnt - fe0, 0);
        chk("fs_rx_data", rx_data, 8'h3C);

        // Framing error followed by 40 extra low cycles
        dr0 = dr_cnt; fe0 = fe_cnt;
        send_frame(8'h5A, 1'b0, CPB, CPB, CPB + 40);
        chk("fe_busy_break", rx_busy, 1'b1);
        repeat (6) @(negedge clk);
        chk("fe_busy_release", rx_busy, 1'b0);
        repeat (200) @(negedge clk);
        chk("fe_cnt", fe_cnt - fe0, 1);
        chk("fe_ready", dr_cnt - dr0, 0);
        chk("fe_rx_data", rx_data, 8'h3C);
        chk("fe_busy_after", rx_busy, 1'b0);

        // Skew: slow 17, jittered 15/17, and fast 16/15 (a flat 15 exceeds the tolerance band)
        dr0 = dr_cnt; fe0 = fe_cnt; q0 = dr_q.size();
        send_frame(8'h96, 1'b1, 17, 17, 17);
        send_frame(8'h96, 1'b1, 15, 17, 17);
        send_frame(8'h96, 1'b1, 16, 15, 16);
        repeat (10) @(negedge clk);
        chk("skew_cnt", dr_cnt - dr0, 3);
        chk("skew_slow", dr_q[q0], 8'h96);
        chk("skew_jitter", dr_q[q0+1], 8'h96);
        chk("skew_fast", dr_q[q0+2], 8'h96);
        chk("skew_ferr", fe_cnt - fe0, 0);

        // Reset during data bit 3 of 8'hC3
        dr0 = dr_cnt; fe0 = fe_cnt;
        rx = 1'b0; repeat (CPB) @(negedge clk);
        rx = 1'b1; repeat (CPB) @(negedge clk);
        rx = 1'b1; repeat (CPB) @(negedge clk);
        rx = 1'b0; repeat (CPB) @(negedge clk);
        rx = 1'b0; repeat (8) @(negedge clk);
        chk("rst_pre_busy", rx_busy, 1'b1);
        rst = 1'b1;
        #1;
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_ready", data_ready, 1'b0);
        chk("rst_ferr", frame_err, 1'b0);
        chk("rst_busy", rx_busy, 1'b0);
        @(negedge clk);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_no_pulse", (dr_cnt - dr0) + (fe_cnt - fe0), 0);
        q0 = dr_q.size();
        send_frame(8'h81, 1'b1, CPB, CPB, CPB);
        repeat (10) @(negedge clk);
        chk("post_rst_cnt", dr_q.size() - q0, 1);
        chk("post_rst_val", rx_data, 8'h81);

        chk("pulse_width", pulse_err, 0);
        chk("exclusive", excl_err, 0);
        chk("busy_gap_final", busy_gap, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Asynchronous serial receiver for the UART core: the receive path feeding `rx_data`/`data_ready` on the parallel side. It covers the direction opposite to the transmitter.
- Line format: 8N1, LSB first, idle-high line.
- The block synchronizes the `rx` pin, validates the start bit, and samples each bit at mid-bit using a per-bit clock counter.
- A completed byte is presented with a one-cycle ready pulse, or flagged as a framing error.

## Interface
- `CLKS_PER_BIT`, default 868: `clk` cycles per bit. Legal range is ≥ 4. `HALF = CLKS_PER_BIT/2` (floor). Counter width is `$clog2(CLKS_PER_BIT)`.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `rx`  in  1  serial input, asynchronous to `clk`.
- `rx_data`  out  8  last correctly framed byte. Holds its value until the next good frame.
- `data_ready`  out  1  one-cycle pulse when `rx_data` has just been updated.
- `frame_err`  out  1  one-cycle pulse when the stop bit is sampled low.
- `rx_busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- **Synchronizer:** two flops, both reset to 1, produce `rx_s`. All FSM decisions use `rx_s` only.
- **IDLE:**
  - If `rx_s` = 0: go to START and clear the counter.
- **START:**
  - The counter increments every cycle.
  - At the edge where count = HALF-1, sample `rx_s`.
  - If `rx_s` = 1, it is a glitch: return to IDLE with no output activity.
  - Otherwise clear the counter, clear the bit index, and go to DATA.
- **DATA:**
  - At count = CLKS_PER_BIT-1, sample `rx_s` into the shift register, LSB first (shift right, new bit into bit 7). Clear the counter and increment the bit index.
  - After the 8th sample, go to STOP.
- **STOP:** at count = CLKS_PER_BIT-1, sample `rx_s`.
  - If 1: load `rx_data` from the shift register, pulse `data_ready`, go to IDLE.
  - If 0: pulse `frame_err`, leave `rx_data` unchanged, go to WAIT_IDLE.
- **WAIT_IDLE:** remain until `rx_s` = 1, then go to IDLE. This stops a break condition from retriggering frames.
- **Exclusivity:** `data_ready` and `frame_err` never assert in the same cycle.

## Timing
- **Reset values:**
  - `rx_data` = 8'h00, `data_ready` = 0, `frame_err` = 0, `rx_busy` = 0.
  - FSM = IDLE, counter = 0, bit index = 0, shift register = 0, sync flops = 1.
- **Reference edge t0:** the first `clk` edge at which the `rx` pin is sampled 0.
  - `rx_s` is low after edge t0+1.
  - IDLE→START occurs at edge t0+2.
- **Sample points:**
  - Start-bit sample: edge t0+2+HALF.
  - Data bit i (i = 0..7): edge t0+2+HALF+(i+1)·CLKS_PER_BIT.
  - Stop sample: edge t0+2+HALF+9·CLKS_PER_BIT.
- **Outputs after the stop sample:**
  - `data_ready`/`frame_err` are high for exactly one cycle following the stop-sample edge.
  - `rx_data` changes on that same edge.
  - Example: with CLKS_PER_BIT = 16, `data_ready` is high during the cycle after edge t0+154.
- **`rx_busy`:** registered from the state, so it rises after edge t0+2. It falls on the same edge that raises `data_ready`. After a framing error it falls on the WAIT_IDLE→IDLE edge.
- **Back-to-back frames:** a new start bit may be detected the cycle after returning to IDLE. This allows a 0.5-bit stop-bit margin with no lost frames.
- **Reset mid-frame:** the async assert forces all reset values immediately. No pulse is emitted, and the partial byte is discarded. After release, the receiver waits for `rx_s` to fall.
- **Baud tolerance:** mid-bit sampling tolerates ±4% cumulative baud mismatch over 10 bits at CLKS_PER_BIT ≥ 16.

## Test plan
- **Single frame:** CLKS_PER_BIT = 16, send 8'hA5 (8N1). Required: `rx_data` = 8'hA5, one `data_ready` pulse 154 cycles after t0, `frame_err` stays 0, `rx_busy` high throughout the frame.
- **Back-to-back frames:** send 8'h00, 8'hFF, 8'h3C with minimal stop bits. Required: three `data_ready` pulses with values 00, FF, 3C in order, and no errors.
- **False start:** drive `rx` low for 4 cycles (< HALF), then high. Required: return to IDLE, no `data_ready`/`frame_err`, and `rx_data` unchanged.
- **Framing error:** send 8'h5A with the stop bit low, then hold `rx` low for 40 cycles, then high. Required: one `frame_err` pulse, `rx_data` keeps its prior value, no second frame started, `rx_busy` low after `rx` returns high.
- **Reset mid-frame:** assert `rst` during data bit 3 of 8'hC3. Required: all outputs at reset values immediately. A subsequent frame 8'h81 is then received correctly.
- **Baud skew:** send 8'h96 with the bit period at 15 and 17 cycles (CLKS_PER_BIT = 16). Required: correct byte, no `frame_err`.
